// File: rtl/chan_frame_buffer.sv
// Ping-pong frame buffer: collects channelizer samples into whole frames and streams them out in order.
// Define CHAN_FRAME_BUFFER_POWER_EN to add the Output_power port (I*I+Q*Q of each readout word).
module chan_frame_buffer #(
    parameter int NUM_CHANNELS        = 32,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 25
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Input_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] Input_index,
    input  logic signed [DATA_WIDTH-1:0]   Input_data [2],
    output logic                           Output_valid,
    input  logic                           Output_ready,
    output logic [CHANNEL_INDEX_WIDTH-1:0] Output_index,
    output logic signed [DATA_WIDTH-1:0]   Output_data [2],
    output logic                           Output_last,
`ifdef CHAN_FRAME_BUFFER_POWER_EN
    output logic [2*DATA_WIDTH:0]          Output_power,
`endif
    output logic                           Error_sequence,
    output logic                           Error_overflow
);

    localparam int IW = CHANNEL_INDEX_WIDTH;
    localparam int WW = 2 * DATA_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {W_SYNC, W_FILL, W_DROP} wr_state_t;
    typedef enum logic       {R_IDLE, R_READ}         rd_state_t;

    // Bank b occupies addresses {b, index}; each word packs {Q, I}.
    logic [WW-1:0] mem [2*NUM_CHANNELS];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wr_bank;
    logic          rd_bank;
    logic          rd_bank_nxt;
    logic          free_bank;

    wr_state_t     wr_state;
    wr_state_t     wr_state_nxt;
    logic [IW-1:0] wr_exp;
    logic [IW-1:0] wr_exp_nxt;
    logic          wr_en;
    logic          set_full;
    logic          seq_err;
    logic          ovf_err;

    rd_state_t     rd_state;
    rd_state_t     rd_state_nxt;
    logic [IW-1:0] rd_cnt;
    logic [IW-1:0] rd_cnt_nxt;
    logic [IW-1:0] rd_idx;
    logic          rd_issue;

    logic          s1_valid;
    logic [IW-1:0] s1_idx;
    logic [WW-1:0] s1_word;

    logic          advance;
    logic          free_en;
    logic          bank_free;
    logic          idx_zero;

    assign advance  = !Output_valid || Output_ready;
    assign free_en  = Output_valid && Output_ready && Output_last;
    assign idx_zero = (Input_index == '0);
    // A bank released this very cycle already counts as free for the writer.
    assign bank_free = !full[wr_bank] || (free_en && (free_bank == wr_bank));

    // ------------------------------------------------------------------ writer
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_exp_nxt   = wr_exp;
        wr_en        = 1'b0;
        set_full     = 1'b0;
        seq_err      = 1'b0;
        ovf_err      = 1'b0;
        unique case (wr_state)
            W_SYNC: begin
                if (Input_valid && idx_zero) begin
                    if (bank_free) begin
                        wr_en        = 1'b1;
                        wr_exp_nxt   = IDX_ONE;
                        wr_state_nxt = W_FILL;
                    end else begin
                        ovf_err      = 1'b1;
                        wr_state_nxt = W_DROP;
                    end
                end
            end
            W_DROP: begin
                if (Input_valid && idx_zero && bank_free) begin
                    wr_en        = 1'b1;
                    wr_exp_nxt   = IDX_ONE;
                    wr_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (Input_valid) begin
                    if (Input_index == wr_exp) begin
                        wr_en = 1'b1;
                        if (wr_exp == LAST_IDX) begin
                            set_full     = 1'b1;
                            wr_state_nxt = W_SYNC;
                        end else begin
                            wr_exp_nxt = wr_exp + IDX_ONE;
                        end
                    end else begin
                        // Partial frame is abandoned; a fresh index 0 restarts it in place.
                        seq_err = 1'b1;
                        if (idx_zero) begin
                            wr_en      = 1'b1;
                            wr_exp_nxt = IDX_ONE;
                        end else begin
                            wr_state_nxt = W_SYNC;
                        end
                    end
                end
            end
            default: wr_state_nxt = W_SYNC;
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (free_en)  full_nxt[free_bank] = 1'b0;
        if (set_full) full_nxt[wr_bank]   = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_state       <= W_SYNC;
            wr_exp         <= '0;
            wr_bank        <= 1'b0;
            free_bank      <= 1'b0;
            full           <= 2'b00;
            Error_sequence <= 1'b0;
            Error_overflow <= 1'b0;
        end else begin
            wr_state       <= wr_state_nxt;
            wr_exp         <= wr_exp_nxt;
            full           <= full_nxt;
            Error_sequence <= seq_err;
            Error_overflow <= ovf_err;
            if (set_full) wr_bank   <= ~wr_bank;
            if (free_en)  free_bank <= ~free_bank;
        end
    end

    // ------------------------------------------------------------------ reader
    always_comb begin
        rd_state_nxt = rd_state;
        rd_cnt_nxt   = rd_cnt;
        rd_bank_nxt  = rd_bank;
        rd_issue     = 1'b0;
        rd_idx       = rd_cnt;
        unique case (rd_state)
            R_IDLE: begin
                if (advance && full[rd_bank]) begin
                    rd_issue     = 1'b1;
                    rd_idx       = '0;
                    rd_cnt_nxt   = IDX_ONE;
                    rd_state_nxt = R_READ;
                end
            end
            R_READ: begin
                if (advance) begin
                    rd_issue = 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        // Going idle here costs no bubble: IDLE issues the next bank's word 0 on the following edge.
                        rd_cnt_nxt   = '0;
                        rd_bank_nxt  = ~rd_bank;
                        rd_state_nxt = R_IDLE;
                    end else begin
                        rd_cnt_nxt = rd_cnt + IDX_ONE;
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // NOTE: the frame store has no reset; the full flags gate every read, so stale contents are never emitted.
    always_ff @(posedge Clk) begin
        if (Rst && wr_en) mem[{wr_bank, Input_index}] <= {Input_data[1], Input_data[0]};
        if (rd_issue)     s1_word <= mem[{rd_bank, rd_idx}];
    end

`ifdef CHAN_FRAME_BUFFER_POWER_EN
    logic signed [DATA_WIDTH-1:0] s1_i;
    logic signed [DATA_WIDTH-1:0] s1_q;
    logic signed [WW:0]           ext_i;
    logic signed [WW:0]           ext_q;
    logic signed [WW:0]           pow_sum;

    assign s1_i    = s1_word[DATA_WIDTH-1:0];
    assign s1_q    = s1_word[WW-1:DATA_WIDTH];
    assign ext_i   = (WW+1)'(s1_i);
    assign ext_q   = (WW+1)'(s1_q);
    assign pow_sum = ext_i * ext_i + ext_q * ext_q;
`endif

    // Memory-read stage and output register stall together whenever the output word is held.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rd_state       <= R_IDLE;
            rd_cnt         <= '0;
            rd_bank        <= 1'b0;
            s1_valid       <= 1'b0;
            s1_idx         <= '0;
            Output_valid   <= 1'b0;
            Output_last    <= 1'b0;
            Output_index   <= '0;
            Output_data[0] <= '0;
            Output_data[1] <= '0;
`ifdef CHAN_FRAME_BUFFER_POWER_EN
            Output_power   <= '0;
`endif
        end else begin
            rd_state <= rd_state_nxt;
            rd_cnt   <= rd_cnt_nxt;
            rd_bank  <= rd_bank_nxt;
            if (advance) begin
                s1_valid     <= rd_issue;
                s1_idx       <= rd_idx;
                Output_valid <= s1_valid;
                Output_last  <= s1_valid && (s1_idx == LAST_IDX);
                if (s1_valid) begin
                    Output_index   <= s1_idx;
                    Output_data[0] <= s1_word[DATA_WIDTH-1:0];
                    Output_data[1] <= s1_word[WW-1:DATA_WIDTH];
`ifdef CHAN_FRAME_BUFFER_POWER_EN
                    Output_power   <= $unsigned(pow_sum);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_chan_frame_buffer.sv
// Self-checking bench for chan_frame_buffer: frame-level reference model plus directed and random traffic.
// Define CHAN_FRAME_BUFFER_POWER_EN to also check Output_power.
module tb_chan_frame_buffer;

    localparam int N  = 32;
    localparam int IW = 5;
    localparam int DW = 25;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic [IW-1:0]        in_index = '0;
    logic signed [DW-1:0] in_data [2];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [IW-1:0]        out_index;
    logic signed [DW-1:0] out_data [2];
    logic                 out_last;
    logic                 err_seq;
    logic                 err_ovf;
`ifdef CHAN_FRAME_BUFFER_POWER_EN
    logic [2*DW:0]        out_power;
`endif

    chan_frame_buffer #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
        .Clk            (clk),
        .Rst            (rst),
        .Input_valid    (in_valid),
        .Input_index    (in_index),
        .Input_data     (in_data),
        .Output_valid   (out_valid),
        .Output_ready   (out_ready),
        .Output_index   (out_index),
        .Output_data    (out_data),
        .Output_last    (out_last),
`ifdef CHAN_FRAME_BUFFER_POWER_EN
        .Output_power   (out_power),
`endif
        .Error_sequence (err_seq),
        .Error_overflow (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int i;
        int q;
    } word_t;

    // Reference model: completed frames awaiting readout, the frame being collected, and bank occupancy.
    word_t exp_q [$];
    word_t cur   [$];
    bit    collecting;
    bit    dropping;
    int    exp_idx;
    int    pending;
    bit    exp_seq;
    bit    exp_ovf;

    int compared   = 0;
    int mismatched = 0;
    int accepted   = 0;
    int seq_pulses = 0;
    int ovf_pulses = 0;
    int last_q_seen = 0;
    longint pow7 = -1;

    task automatic check(string name, longint act, longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        cur.delete();
        collecting = 1'b0;
        dropping   = 1'b0;
        exp_idx    = 0;
        pending    = 0;
    endfunction

    function automatic void model_sample(int idx, int i, int q);
        word_t w;
        w = '{idx, i, q};
        if (collecting) begin
            if (idx == exp_idx) begin
                cur.push_back(w);
                if (idx == N - 1) begin
                    foreach (cur[k]) exp_q.push_back(cur[k]);
                    cur.delete();
                    pending++;
                    collecting = 1'b0;
                end else begin
                    exp_idx++;
                end
            end else begin
                exp_seq = 1'b1;
                cur.delete();
                if (idx == 0) begin
                    cur.push_back(w);
                    exp_idx = 1;
                end else begin
                    collecting = 1'b0;
                end
            end
        end else if (idx == 0) begin
            if (pending < 2) begin
                collecting = 1'b1;
                dropping   = 1'b0;
                cur.delete();
                cur.push_back(w);
                exp_idx = 1;
            end else if (!dropping) begin
                dropping = 1'b1;
                exp_ovf  = 1'b1;
            end
        end
    endfunction

    // One clock: compare outputs at the falling edge, drive the next inputs, advance the model.
    task automatic step(bit rst_v, bit v, int idx, int i, int q, bit rdy);
        word_t w;
        @(negedge clk);
        check("error_sequence", err_seq, exp_seq);
        check("error_overflow", err_ovf, exp_ovf);
        seq_pulses += int'(err_seq);
        ovf_pulses += int'(err_ovf);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                w = exp_q[0];
                check("out_index", out_index, w.idx);
                check("out_i", out_data[0], w.i);
                check("out_q", out_data[1], w.q);
                check("out_last", out_last, (w.idx == N - 1));
`ifdef CHAN_FRAME_BUFFER_POWER_EN
                check("out_power", out_power, longint'(w.i) * w.i + longint'(w.q) * w.q);
                if (out_index == 7) pow7 = longint'(out_power);
`endif
                if (out_last) last_q_seen = int'(out_data[1]);
            end
        end
        rst        = rst_v;
        in_valid   = v;
        in_index   = IW'(idx);
        in_data[0] = DW'(i);
        in_data[1] = DW'(q);
        out_ready  = rdy;
        exp_seq    = 1'b0;
        exp_ovf    = 1'b0;
        if (!rst_v) begin
            model_reset();
        end else begin
            if (out_valid && rdy && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                accepted++;
                if (w.idx == N - 1) pending--;
            end
            if (v) model_sample(idx, i, q);
        end
    endtask

    function automatic bit pick_ready(bit rdy_fixed, bit rdy);
        return rdy_fixed ? rdy : ($urandom_range(99) < 60);
    endfunction

    function automatic int rand_data();
        logic signed [DW-1:0] r;
        case ($urandom_range(9))
            0:       r = {1'b1, {(DW-1){1'b0}}};
            1:       r = {1'b0, {(DW-1){1'b1}}};
            default: r = DW'($urandom);
        endcase
        return int'(r);
    endfunction

    // kind 0: I=k, Q=-k; kind 1: random; kind 2: random with I=3, Q=-4 at index 7.
    task automatic send_frame(int kind, bit rdy_fixed, bit rdy, int gap_pct, int err_pct);
        int idx, i, q;
        for (int k = 0; k < N; k++) begin
            idx = k;
            if (err_pct > 0 && $urandom_range(99) < err_pct) idx = (k + 1 + $urandom_range(N - 2)) % N;
            if (kind == 0) begin
                i = k;
                q = -k;
            end else begin
                i = rand_data();
                q = rand_data();
            end
            if (kind == 2 && k == 7) begin
                i = 3;
                q = -4;
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1, 0, 0, 0, 0, pick_ready(rdy_fixed, rdy));
            step(1, 1, idx, i, q, pick_ready(rdy_fixed, rdy));
        end
    endtask

    task automatic drain(int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) step(1, 0, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0, 1);
        check("drain_left", exp_q.size(), 0);
    endtask

    int a0, s0, o0, cnt;
    bit v1, v2, v3;

    initial begin
        model_reset();
        exp_seq = 1'b0;
        exp_ovf = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset with active inputs that must be ignored.
        for (int k = 0; k < 4; k++) step(0, 1, k, 100 + k, -k, 1);
        step(1, 0, 0, 0, 0, 1);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_index", out_index, 0);
        check("rst_i", out_data[0], 0);
        check("rst_q", out_data[1], 0);
        check("rst_err_seq", err_seq, 0);
        check("rst_err_ovf", err_ovf, 0);

        // Basic frame with known data, plus first-word latency.
        a0 = accepted; s0 = seq_pulses; o0 = ovf_pulses;
        send_frame(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1); v1 = out_valid;
        step(1, 0, 0, 0, 0, 1); v2 = out_valid;
        step(1, 0, 0, 0, 0, 1); v3 = out_valid;
        check("latency_pattern", {v1, v2, v3}, 3'b001);
        drain(200);
        check("basic_words", accepted - a0, 32);
        check("basic_last_q", last_q_seen, -31);
        check("basic_seq_pulses", seq_pulses - s0, 0);
        check("basic_ovf_pulses", ovf_pulses - o0, 0);

        // Two frames held back, then released as one contiguous stream.
        a0 = accepted;
        send_frame(1, 1, 0, 0, 0);
        send_frame(1, 1, 0, 20, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int n = 0; n < 64; n++) begin
            step(1, 0, 0, 0, 0, 1);
            cnt += int'(out_valid);
        end
        check("b2b_contiguous", cnt, 64);
        drain(50);
        check("b2b_words", accepted - a0, 64);

        // Overflow: third frame while both banks are full is dropped, fourth passes.
        a0 = accepted; o0 = ovf_pulses;
        send_frame(1, 1, 0, 0, 0);
        send_frame(0, 1, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0);
        drain(200);
        send_frame(1, 1, 1, 0, 0);
        drain(200);
        check("ovf_pulses", ovf_pulses - o0, 1);
        check("ovf_words", accepted - a0, 96);

        // Index discontinuity 0,1,2,5,...: partial frame discarded.
        a0 = accepted; s0 = seq_pulses;
        for (int k = 0; k < N; k++) if (k != 3 && k != 4) step(1, 1, k, k + 7, k - 7, 1);
        repeat (6) step(1, 0, 0, 0, 0, 1);
        check("seq_nothing_out", accepted - a0, 0);
        send_frame(1, 1, 1, 0, 0);
        drain(200);
        check("seq_pulses", seq_pulses - s0, 1);
        check("seq_words", accepted - a0, 32);

        // Reset during readout.
        send_frame(1, 1, 1, 0, 0);
        for (int n = 0; n < 100 && !(out_valid && out_index == 10); n++) step(1, 0, 0, 0, 0, 1);
        check("mid_reached_word10", out_valid && out_index == 10, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_index", out_index, 0);
        a0 = accepted;
        for (int k = 5; k < N; k++) step(1, 1, k, k, k, 1);
        send_frame(0, 1, 1, 0, 0);
        drain(200);
        check("mid_rst_words", accepted - a0, 32);

`ifdef CHAN_FRAME_BUFFER_POWER_EN
        send_frame(2, 1, 1, 0, 0);
        drain(200);
        check("power_pin_idx7", pow7, 25);
`endif

        // Random traffic: gaps, backpressure and occasional index errors.
        for (int f = 0; f < 14; f++) send_frame(1, 0, 0, 25, (f % 3 == 2) ? 4 : 0);
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/chan_frame_buffer.md
CHAN_FRAME_BUFFER -- requirements
Module: chan_frame_buffer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 32, meaning channels per frame (power of 2, 4..64).
REQ-002 SHALL have parameter CHANNEL_INDEX_WIDTH, default $clog2(NUM_CHANNELS), meaning index width.
REQ-003 SHALL have parameter DATA_WIDTH, default 25, meaning channelizer output I/Q width.
REQ-004 SHALL have port Clk  in  1  clock.
REQ-005 SHALL have port Rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port Input_valid  in  1  channelizer output sample strobe.
REQ-007 SHALL have port Input_index  in  CHANNEL_INDEX_WIDTH  channel index of sample.
REQ-008 SHALL have port Input_data  in  2 x DATA_WIDTH signed  [0]=I, [1]=Q.
REQ-009 SHALL have port Output_valid  out  1  readout word valid.
REQ-010 SHALL have port Output_ready  in  1  downstream accept.
REQ-011 SHALL have port Output_index  out  CHANNEL_INDEX_WIDTH  channel of readout word.
REQ-012 SHALL have port Output_data  out  2 x DATA_WIDTH signed  readout I/Q.
REQ-013 SHALL have port Output_last  out  1  high with index NUM_CHANNELS-1.
REQ-014 SHALL have port Error_sequence  out  1  one-cycle pulse on index discontinuity.
REQ-015 SHALL have port Error_overflow  out  1  one-cycle pulse on dropped complete frame.

Function
REQ-016 SHALL hold two frame banks (ping-pong), each NUM_CHANNELS x I/Q, each with a full flag.
REQ-017 Writer FSM SHALL have states SYNC, FILL, DROP; SYNC waits for Input_valid with Input_index=0, writes it, enters FILL (expected=1).
REQ-018 In FILL, a valid sample with Input_index=expected SHALL be written and expected incremented; write of NUM_CHANNELS-1 SHALL set bank full, toggle write bank, enter SYNC.
REQ-019 In FILL, a valid sample with Input_index!=expected SHALL pulse Error_sequence next cycle, discard partial frame; if index=0, restart frame with that sample (stay FILL, expected=1), else enter SYNC.
REQ-020 If the write bank is full at SYNC-to-FILL transition, writer SHALL enter DROP, pulse Error_overflow next cycle, discard samples until next index 0 seen with a free bank.
REQ-021 Reader FSM SHALL have states IDLE, READ; IDLE with read bank full enters READ, emitting indices 0..N-1 in order.
REQ-022 Output_valid/index/data/last SHALL be registered; first word valid 2 cycles after bank full flag sets (memory read + output register).
REQ-023 Output words SHALL hold stable while Output_valid=1 and Output_ready=0; advance only on valid&ready.
REQ-024 On accept of Output_last word the bank SHALL be freed and read bank toggled; if other bank full, next frame streams without gap (back-to-back).
REQ-025 Bank free and writer full-check in same cycle: free SHALL take precedence (no overflow).
REQ-026 Data SHALL pass unmodified (no rounding, sign-preserving).
REQ-027 Frames SHALL be output in arrival order; no frame output twice.

Reset
REQ-028 With Rst=0 at a Clk edge: writer SYNC, reader IDLE, both full flags 0, bank pointers 0, Output_valid/Output_last/Error_sequence/Error_overflow 0, Output_index 0, Output_data 0.
REQ-029 Reset mid-frame or mid-readout SHALL discard all buffered data; first frame after reset requires a fresh index 0.
REQ-030 Inputs SHALL be ignored while Rst=0.

Configuration
REQ-031 Macro CHAN_FRAME_BUFFER_POWER_EN, when defined, SHALL add output Output_power (2*DATA_WIDTH+1 bits unsigned) = I*I+Q*Q of the current readout word, aligned with Output_data.
REQ-032 Without CHAN_FRAME_BUFFER_POWER_EN, port Output_power and multipliers SHALL not exist; all other behaviour identical.

Verification
REQ-033 N=32, frame I=index, Q=-index, Output_ready=1 -> 32 words index 0..31, I=k, Q=-k, Output_last on 31, no errors.
REQ-034 Two frames back-to-back, Output_ready=0 until both received -> both banks full; release ready -> 64 contiguous words, frame 1 then frame 2.
REQ-035 Third frame while both banks full -> Error_overflow single pulse, third frame absent from output, fourth frame (after drain) output intact.
REQ-036 Indices 0,1,2,5,... -> Error_sequence pulse, partial frame discarded, nothing output until a clean 0..31 frame arrives.
REQ-037 Rst=0 asserted at readout word 10 -> Output_valid 0 next cycle; subsequent clean frame output from index 0.
REQ-038 POWER_EN defined, I=3, Q=-4 at index 7 -> Output_power=25 with Output_index=7.
